serial_sub_2bit: RTL and testbench
==================================

// Module: serial_sub_2bit
// PURPOSE
//  Multi-cycle WIDTH-bit subtractor: diff = A - B - BORROW_IN.
//  Processes one 2-bit digit per clock through a 2-bit borrow-lookahead cell, LSB digit first.
//  Complements the combinational 2-bit carry-lookahead adder: the same digit slicing, in the subtract direction.
//  Uses valid/ready handshakes on both sides. Sits between operand registers and a result consumer in the datapath.
// PARAMETERS
//  WIDTH  16  operand/result width; even, >= 2; digit count ND = WIDTH/2
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  IN_VALID   in   1      operands presented
//  IN_READY   out  1      block idle, will accept operands
//  A          in   WIDTH  minuend, unsigned or two's complement
//  B          in   WIDTH  subtrahend
//  BORROW_IN  in   1      incoming borrow, subtracted at bit 0
//  OUT_VALID  out  1      result held valid
//  OUT_READY  in   1      consumer takes result
//  DIFF       out  WIDTH  A - B - BORROW_IN mod 2^WIDTH
//  BORROW_OUT out  1      1 iff A < B + BORROW_IN (unsigned)
//  OVERFLOW   out  1      signed overflow: A[msb]!=B[msb] && DIFF[msb]!=A[msb]
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; IN_READY=0; OUT_VALID=0; DIFF=0; BORROW_OUT=0; OVERFLOW=0.
//  IN_READY rises on the first clk edge after rst_n deasserts. All outputs are registered.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: IN_READY=1. An edge with IN_VALID&&IN_READY loads A, B, BORROW_IN into shift registers.
//         It also captures A[msb] and B[msb], clears digit counter, clears IN_READY, and moves to RUN.
//   RUN: each edge does three things:
//         slice = cell(a_sr[1:0], b_sr[1:0], brw);
//         shifts the A/B registers right by 2 and shifts slice into the result MSB end;
//         updates brw and increments the counter.
//        On the edge where counter==ND-1, move to DONE. On that same edge, load DIFF/BORROW_OUT/OVERFLOW and set OUT_VALID=1.
//   DONE: DIFF, BORROW_OUT, OVERFLOW and OUT_VALID are held stable while OUT_READY=0.
//         An edge with OUT_READY=1 clears OUT_VALID, sets IN_READY and moves to IDLE.
//  Latency: OUT_VALID is high ND cycles after the accept edge. The result is outputted at the ND-th edge after accept.
//  Throughput: one operation per ND+2 cycles. There is no overlap of consecutive operations.
//  IN_VALID and operand changes during RUN/DONE are ignored; operands are sampled only at accept.
//  OUT_READY high before OUT_VALID has no effect.
//  DIFF is kept unchanged after handshake until the next result loads; only OUT_VALID qualifies it.
//  Width rule: no sign extension. DIFF wraps modulo 2^WIDTH. BORROW_OUT is the final digit borrow.
//  Reset mid-RUN or mid-DONE: the operation is abandoned, all outputs return to reset values immediately, and there is no partial result.
//  WIDTH=2: ND=1; RUN lasts one edge.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE/RUN/DONE). Also a function computing counter width $clog2(ND) (min 1).
//  Sub-module sub_2bit_cell (combinational) takes a[1:0], b[1:0], bin and gives d[1:0], bout.
//   It uses generate g=~a&b and propagate p=~(a^b).
//   bout = g1 | p1&g0 | p1&p0&bin.
//  Top level contains FSM, counter, shift registers, MSB capture and output registers. Instantiate exactly one cell.
//  Elaboration check: WIDTH even and >= 2; otherwise $error.
// TESTING (WIDTH=16, ND=8; OUT_READY=1 unless stated)
//  1. A=0x1234 B=0x0034 BIN=0 -> DIFF=0x1200 BORROW_OUT=0 OVERFLOW=0; OUT_VALID exactly 8 cycles after accept.
//  2. A=0x0000 B=0x0001 BIN=0 -> DIFF=0xFFFF BORROW_OUT=1 OVERFLOW=0.
//  3. A=0x8000 B=0x0001 BIN=0 -> DIFF=0x7FFF BORROW_OUT=0 OVERFLOW=1.
//     Also A=0x7FFF B=0xFFFF -> DIFF=0x8000 BORROW_OUT=1 OVERFLOW=1.
//  4. A=0x0005 B=0x0005 BIN=1 -> DIFF=0xFFFF BORROW_OUT=1 OVERFLOW=0.
//  5. OUT_READY=0 for 5 cycles after OUT_VALID, with IN_VALID=1 and new operands throughout.
//     -> outputs stable, IN_READY=0, the new operands are not taken. Release -> IDLE; next accept gives the correct new result.
//  6. rst_n low at RUN digit 3 -> outputs 0 asynchronously, IN_READY=0 during reset and 1 one edge after release.
//     The following op (A=0xFFFF B=0x1111) -> 0xEEEE.
//  Plus a random back-to-back run of 1000 ops vs a reference model (A-B-BIN), with random OUT_READY stalls.

Source files
------------

// File: rtl/serial_sub_2bit_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_sub_2bit_pkg
// Purpose  : Shared state encoding and sizing helpers for the digit-serial
//            2-bit borrow-lookahead subtractor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_sub_2bit_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Digit counter width: enough to count 0..nd-1, never narrower than 1 bit
  function automatic int cnt_width(input int nd);
    return (nd <= 1) ? 1 : $clog2(nd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_sub_2bit_cell.sv
//------------------------------------------------------------------------------
// Module   : sub_2bit_cell
// Purpose  : Combinational 2-bit borrow-lookahead subtract cell:
//            {bout, d} = a - b - bin over one 2-bit digit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sub_2bit_cell (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       bin,
  output logic [1:0] d,
  output logic       bout
);

  // Borrow generate: this bit borrows regardless of the incoming borrow.
  // Borrow propagate: this bit passes an incoming borrow through.
  logic [1:0] g;
  logic [1:0] p;
  logic       b0_out;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Internal borrow out of bit 0, used only to form the bit-1 difference
  assign b0_out = g[0] | (p[0] & bin);

  assign d[0] = a[0] ^ b[0] ^ bin;
  assign d[1] = a[1] ^ b[1] ^ b0_out;

  // Lookahead digit borrow, not rippled through b0_out
  assign bout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);

endmodule

`default_nettype wire

// File: rtl/serial_sub_2bit.sv
//------------------------------------------------------------------------------
// Module   : serial_sub_2bit
// Purpose  : Multi-cycle WIDTH-bit subtractor DIFF = A - B - BORROW_IN, one
//            2-bit digit per clock (LSB digit first) through a single
//            borrow-lookahead cell, with valid/ready on both sides.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_sub_2bit
  import serial_sub_2bit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BORROW_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW_OUT,
  output logic             OVERFLOW
);

  localparam int ND = WIDTH / 2;
  localparam int CW = cnt_width(ND);
  // Partial-result register holds every digit except the last one, which
  // goes straight from the cell into DIFF on the final edge.
  localparam int RW = (WIDTH > 2) ? WIDTH - 2 : 2;

  // Reject odd or too-narrow widths at elaboration
  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_check
    $error("serial_sub_2bit: WIDTH must be even and >= 2");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [RW-1:0]     res_q, res_d;
  logic              brw_q, brw_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              ovf_q, ovf_d;

  logic [1:0]        cell_d;
  logic              cell_bout;
  logic [WIDTH-1:0]  w_full;
  logic [RW-1:0]     w_res_next;

  sub_2bit_cell u_cell (
    .a    (a_q[1:0]),
    .b    (b_q[1:0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Result assembly: new digit enters at the MSB end of the partial result
  if (WIDTH == 2) begin : g_nd1
    assign w_full     = cell_d;
    assign w_res_next = res_q;
  end else if (WIDTH == 4) begin : g_nd2
    assign w_full     = {cell_d, res_q};
    assign w_res_next = cell_d;
  end else begin : g_ndn
    assign w_full     = {cell_d, res_q};
    assign w_res_next = {cell_d, res_q[RW-1:2]};
  end

  // Next-state logic for FSM, datapath shift registers and output registers
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    brw_d       = brw_q;
    cnt_d       = cnt_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE: begin
        // READY comes up one edge after reset release, then stays up in IDLE
        in_ready_d = 1'b1;
        if (IN_VALID && in_ready_q) begin
          a_d        = A;
          b_d        = B;
          brw_d      = BORROW_IN;
          a_msb_d    = A[WIDTH-1];
          b_msb_d    = B[WIDTH-1];
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 2;
        b_d   = b_q >> 2;
        res_d = w_res_next;
        brw_d = cell_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ND - 1)) begin
          state_d     = S_DONE;
          diff_d      = w_full;
          borrow_d    = cell_bout;
          // Signed overflow only when operand signs differ and the result
          // sign disagrees with the minuend
          ovf_d       = (a_msb_q != b_msb_q) && (cell_d[1] != a_msb_q);
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; async reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      brw_q       <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      brw_q       <= brw_d;
      cnt_q       <= cnt_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
    end
  end

  assign IN_READY   = in_ready_q;
  assign OUT_VALID  = out_valid_q;
  assign DIFF       = diff_q;
  assign BORROW_OUT = borrow_q;
  assign OVERFLOW   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_2bit.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_sub_2bit
// Purpose  : Self-checking bench for serial_sub_2bit (WIDTH=16).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_sub_2bit;

  logic        clk;
  logic        rst_n;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] A;
  logic [15:0] B;
  logic        BORROW_IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] DIFF;
  logic        BORROW_OUT;
  logic        OVERFLOW;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  serial_sub_2bit #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .A          (A),
    .B          (B),
    .BORROW_IN  (BORROW_IN),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .DIFF       (DIFF),
    .BORROW_OUT (BORROW_OUT),
    .OVERFLOW   (OVERFLOW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One operation: wait for READY, accept, time the latency, check the result,
  // optionally complete the output handshake (with random stalls if rnd).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] ed, input logic eb, input logic eo,
                        input bit rnd, input bit do_hs);
    int  k;
    bit  hs;
    k = 0;
    while (!IN_READY && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_before_accept", IN_READY, 1);
    A = a; B = b; BORROW_IN = bin; IN_VALID = 1'b1;
    if (rnd) OUT_READY = 1'($urandom_range(0, 1));
    @(posedge clk);
    k = 0;
    @(negedge clk);
    IN_VALID  = 1'b0;
    A         = 16'($urandom);
    B         = 16'($urandom);
    BORROW_IN = 1'($urandom_range(0, 1));
    while (!OUT_VALID && k < 50) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (rnd) OUT_READY = 1'($urandom_range(0, 1));
    end
    chk("latency", k, 8);
    chk("diff", DIFF, ed);
    chk("borrow_out", BORROW_OUT, eb);
    chk("overflow", OVERFLOW, eo);
    chk("in_ready_in_done", IN_READY, 0);
    if (do_hs) begin
      k = 0;
      do begin
        OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        hs = OUT_READY;
        @(negedge clk);
        k++;
      end while (!hs && k < 100);
      chk("out_valid_after_hs", OUT_VALID, 0);
      chk("in_ready_after_hs", IN_READY, 1);
      chk("diff_held_after_hs", DIFF, ed);
    end
  endtask

  initial begin
    logic [16:0] r;
    logic [15:0] ra, rb;
    logic        rbin;
    n_vec = 0;
    n_bad = 0;

    vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'hAAAA, 16'h5555, 1'b0, 16'h5555, 1'b0, 1'b1};
    vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};

    // Reset state
    rst_n = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    A = '0; B = '0; BORROW_IN = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_diff", DIFF, 0);
    chk("rst_borrow", BORROW_OUT, 0);
    chk("rst_overflow", OVERFLOW, 0);
    rst_n = 1'b1;
    #1 chk("in_ready_before_first_edge", IN_READY, 0);
    @(negedge clk);
    chk("in_ready_after_release", IN_READY, 1);

    // Directed table
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf, 1'b0, 1'b1);

    // Reset in the middle of RUN, with a nonzero previous result held
    @(negedge clk);
    A = 16'h1234; B = 16'h0034; BORROW_IN = 1'b0; IN_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    IN_VALID = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_diff", DIFF, 0);
    chk("midrun_rst_borrow", BORROW_OUT, 0);
    chk("midrun_rst_overflow", OVERFLOW, 0);
    chk("midrun_rst_out_valid", OUT_VALID, 0);
    chk("midrun_rst_in_ready", IN_READY, 0);
    @(negedge clk);
    chk("midrun_rst_in_ready_held", IN_READY, 0);
    rst_n = 1'b1;
    #1 chk("midrun_release_in_ready", IN_READY, 0);
    @(negedge clk);
    chk("midrun_release_in_ready_edge", IN_READY, 1);
    repeat (10) begin
      @(negedge clk);
      chk("no_partial_result", OUT_VALID, 0);
    end
    run_op(16'hFFFF, 16'h1111, 1'b0, 16'hEEEE, 1'b0, 1'b0, 1'b0, 1'b1);

    // Output stall with new operands pushed during DONE
    OUT_READY = 1'b0;
    run_op(16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      IN_VALID = 1'b1; A = 16'h9999; B = 16'h1111; BORROW_IN = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("stall_out_valid", OUT_VALID, 1);
      chk("stall_diff", DIFF, 16'h3210);
      chk("stall_borrow", BORROW_OUT, 0);
      chk("stall_in_ready", IN_READY, 0);
    end
    OUT_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_release_out_valid", OUT_VALID, 0);
    chk("stall_release_in_ready", IN_READY, 1);
    run_op(16'h9999, 16'h1111, 1'b0, 16'h8888, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random back-to-back operations against an arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      r    = {1'b0, ra} - {1'b0, rb} - {16'b0, rbin};
      run_op(ra, rb, rbin, r[15:0], r[16], (ra[15] != rb[15]) && (r[15] != ra[15]),
             1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
